// File: rtl/my_regfile_pkg.sv
// regfile_pkg: shared widths and word/address types for the register file
package regfile_pkg;
  localparam int REG_DW = 16;
  localparam int REG_AW = 4;
  localparam int REG_N = 1 << REG_AW;
  typedef logic [REG_DW-1:0] reg_word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/my_regfile_if.sv
// my_regfile_if: read/write port bundle of the register file
interface my_regfile_if
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
);
  logic [AW-1:0] n1;
  logic [DW-1:0] rd1;
  logic [AW-1:0] n2;
  logic [DW-1:0] rd2;
  logic we;
  logic [AW-1:0] wn;
  logic [DW-1:0] wd;
  modport master (output n1, n2, we, wn, wd, input rd1, rd2);
  modport slave (input n1, n2, we, wn, wd, output rd1, rd2);
endinterface

// File: rtl/my_regfile_word.sv
// regfile_word: one register with sync reset to INIT and a load enable
module regfile_word
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;
  always_comb q_d = en_i ? d_i : q_q;
  always_ff @(posedge clk) q_q <= rst ? INIT : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/my_regfile.sv
// my_regfile: 2-read/1-write register file, entry i resets to i, no write bypass
module my_regfile
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input logic clk,
  input logic rst,
  my_regfile_if.slave rf
);
  localparam int N = 1 << AW;
  logic [DW-1:0] words [N];
  logic [N-1:0] en;
  for (genvar g = 0; g < N; g++) begin : g_word
    assign en[g] = rf.we && (rf.wn == AW'(g));
    regfile_word #(.DW(DW), .INIT(DW'(g))) u_word (
      .clk  (clk),
      .rst  (rst),
      .en_i (en[g]),
      .d_i  (rf.wd),
      .q_o  (words[g])
    );
  end
  always_comb begin
    rf.rd1 = words[rf.n1];
    rf.rd2 = words[rf.n2];
  end
endmodule

// File: tb/tb_my_regfile.sv
// tb_my_regfile: directed and random checks against an array model of the register file
module tb_my_regfile;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  reg_word_t m [16];
  my_regfile_if #(.DW(16), .AW(4)) rf ();
  my_regfile #(.DW(16), .AW(4)) dut (.clk(clk), .rst(rst), .rf(rf));
  always #5 clk = ~clk;
  task automatic check(input string tag, input reg_word_t obs, input reg_word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) m[i] = reg_word_t'(i);
    #1 rst = 1'b0;
  endtask
  task automatic wr(input int a, input reg_word_t d);
    rf.we = 1'b1;
    rf.wn = reg_addr_t'(a);
    rf.wd = d;
    @(posedge clk);
    m[a] = d;
    #1 rf.we = 1'b0;
  endtask
  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rf.n1 = reg_addr_t'(i);
      rf.n2 = reg_addr_t'(15 - i);
      #1;
      check({tag, "_rd1"}, rf.rd1, m[i]);
      check({tag, "_rd2"}, rf.rd2, m[15 - i]);
    end
  endtask
  initial begin
    rf.n1 = '0; rf.n2 = '0; rf.we = 1'b0; rf.wn = '0; rf.wd = '0;
    @(negedge clk);
    do_rst();
    for (int k = 0; k < 10; k++) begin
      rf.n1 = reg_addr_t'(k);
      rf.n2 = reg_addr_t'(k < 6 ? 15 - k : 10);
      #1;
      check("sweep_rd1", rf.rd1, reg_word_t'(k));
      check("sweep_rd2", rf.rd2, reg_word_t'(k < 6 ? 15 - k : 10));
      #9;
    end
    wr(5, 16'hBEEF);
    rf.n1 = 4'd5; #1 check("wr5", rf.rd1, 16'hBEEF);
    rf.n1 = 4'd4; #1 check("wr5_nb4", rf.rd1, 16'd4);
    rf.n1 = 4'd6; #1 check("wr5_nb6", rf.rd1, 16'd6);
    @(negedge clk);
    rf.n1 = 4'd7; rf.n2 = 4'd7; rf.wn = 4'd7; rf.wd = 16'h1234; rf.we = 1'b1;
    #1;
    check("coll_pre_rd1", rf.rd1, 16'd7);
    check("coll_pre_rd2", rf.rd2, 16'd7);
    @(posedge clk); m[7] = 16'h1234; #1 rf.we = 1'b0;
    check("coll_post_rd1", rf.rd1, 16'h1234);
    check("coll_post_rd2", rf.rd2, 16'h1234);
    rf.we = 1'b1; rf.wn = 4'd3; rf.wd = 16'hFFFF;
    do_rst();
    rf.we = 1'b0;
    rf.n1 = 4'd3; #1 check("rst_prio", rf.rd1, 16'd3);
    check_all("rst_img");
    for (int i = 0; i < 16; i++) wr(i, 16'hA5A5);
    check_all("fill");
    do_rst();
    check_all("refill_rst");
    wr(0, 16'h0001);
    wr(15, 16'h8000);
    rf.n1 = 4'd0; rf.n2 = 4'd15; #1;
    check("dual_rd1", rf.rd1, 16'h0001);
    check("dual_rd2", rf.rd2, 16'h8000);
    rf.n1 = 4'd15; rf.n2 = 4'd0; #1;
    check("swap_rd1", rf.rd1, 16'h8000);
    check("swap_rd2", rf.rd2, 16'h0001);
    do_rst();
    for (int c = 0; c < 20; c++) begin
      rf.wn = reg_addr_t'($urandom_range(15));
      rf.wd = reg_word_t'($urandom);
      @(posedge clk); #1;
    end
    check_all("we0_hold");
    for (int c = 0; c < 200; c++) begin
      int a;
      reg_word_t d;
      a = int'($urandom_range(15));
      d = reg_word_t'($urandom);
      rf.we = 1'($urandom);
      rf.wn = reg_addr_t'(a);
      rf.wd = d;
      rf.n1 = reg_addr_t'($urandom_range(15));
      rf.n2 = ($urandom_range(3) == 0) ? reg_addr_t'(a) : reg_addr_t'($urandom_range(15));
      #1;
      check("rnd_rd1", rf.rd1, m[rf.n1]);
      check("rnd_rd2", rf.rd2, m[rf.n2]);
      @(posedge clk);
      if (rf.we) m[a] = d;
      #1;
    end
    rf.we = 1'b0;
    check_all("rnd_final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
